// File: rtl/opdm_pkg.sv
// Shared definitions for the OPDM sweep sequencer: state encoding and sweep geometry.
package opdm_pkg;

  localparam int OPDM_N_VEC = 16;
  localparam int OPDM_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } opdm_state_t;

endpackage

// File: rtl/opdm_seq_ctrl.sv
// Sweeps all 16 {O,P,D,M} vectors into an external opdm instance and captures H/L per vector.
// state   | meaning
// IDLE    | waiting for i_start, stimulus 0, results held
// APPLY   | vector idx driven, settle timer loaded
// SETTLE  | vector held while the timer counts down to 0
// CAPTURE | H/L sampled into maps/counts, advance or finish
// DONE    | one-cycle o_done pulse, back to IDLE
module opdm_seq_ctrl
  import opdm_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int N_VEC  = OPDM_N_VEC
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_H,
  input  logic                  i_L,
  output logic                  o_O,
  output logic                  o_P,
  output logic                  o_D,
  output logic                  o_M,
  output logic [OPDM_IDX_W-1:0] o_idx,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [OPDM_N_VEC-1:0] o_h_map,
  output logic [OPDM_N_VEC-1:0] o_l_map,
  output logic [4:0]            o_h_cnt,
  output logic [4:0]            o_l_cnt
);

  opdm_state_t           r_state;
  opdm_state_t           w_state_nxt;
  logic [OPDM_IDX_W-1:0] r_idx;
  logic [3:0]            r_settle;
  logic [OPDM_N_VEC-1:0] r_h_map;
  logic [OPDM_N_VEC-1:0] r_l_map;
  logic [4:0]            r_h_cnt;
  logic [4:0]            r_l_cnt;
  logic                  w_accept;
  logic                  w_capture;
  logic                  w_last;
  logic                  w_busy;
  logic [3:0]            w_stim;

  assign w_last    = (r_idx == 4'(N_VEC - 1));
  assign w_accept  = (r_state == ST_IDLE) && i_start && !i_abort;
  // Abort wins over capture so an aborted vector never lands in the maps.
  assign w_capture = (r_state == ST_CAPTURE) && !i_abort;
  assign w_busy    = (r_state == ST_APPLY) || (r_state == ST_SETTLE) || (r_state == ST_CAPTURE);
  assign w_stim    = w_busy ? r_idx : 4'b0000;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_accept) w_state_nxt = ST_APPLY;
      ST_APPLY:   w_state_nxt = ST_SETTLE;
      ST_SETTLE:  if (r_settle == 4'd0) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = w_last ? ST_DONE : ST_APPLY;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
    if (i_abort && (r_state != ST_IDLE)) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx    <= '0;
      r_settle <= '0;
      r_h_map  <= '0;
      r_l_map  <= '0;
      r_h_cnt  <= '0;
      r_l_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_idx   <= '0;
        r_h_map <= '0;
        r_l_map <= '0;
        r_h_cnt <= '0;
        r_l_cnt <= '0;
      end
      if (r_state == ST_APPLY) r_settle <= 4'(SETTLE - 1);
      else if ((r_state == ST_SETTLE) && (r_settle != 4'd0)) r_settle <= r_settle - 4'd1;
      if (w_capture) begin
        r_h_map[r_idx] <= i_H;
        r_l_map[r_idx] <= i_L;
        r_h_cnt        <= r_h_cnt + {4'b0000, i_H};
        r_l_cnt        <= r_l_cnt + {4'b0000, i_L};
        if (!w_last) r_idx <= r_idx + 4'd1;
      end
    end
  end

  assign {o_O, o_P, o_D, o_M} = w_stim;
  assign o_idx   = r_idx;
  assign o_busy  = w_busy;
  assign o_done  = (r_state == ST_DONE);
  assign o_h_map = r_h_map;
  assign o_l_map = r_l_map;
  assign o_h_cnt = r_h_cnt;
  assign o_l_cnt = r_l_cnt;

endmodule

// File: doc/opdm_seq_ctrl.md
OPDM_SEQ_CTRL -- requirements
Module: opdm_seq_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 2, meaning cycles the vector is held before capture (legal 1..15).
REQ-002 SHALL have parameter N_VEC, default 16, meaning vectors per sweep (fixed 16; a 4-bit index covers O,P,D,M).
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_start  input  1  sweep request, sampled in IDLE only.
REQ-006 SHALL have port i_abort  input  1  cancel the sweep in progress.
REQ-007 SHALL have port i_H  input  1  H result from the opdm instance.
REQ-008 SHALL have port i_L  input  1  L result from the opdm instance.
REQ-009 SHALL have ports o_O, o_P, o_D, o_M  output  1 each  stimulus driven to the opdm instance.
REQ-010 SHALL have port o_idx  output  4  current vector index.
REQ-011 SHALL have port o_busy  output  1  sweep in progress.
REQ-012 SHALL have port o_done  output  1  one-cycle pulse when a sweep completes.
REQ-013 SHALL have ports o_h_map, o_l_map  output  16 each  captured H/L per vector; bit n is vector n.
REQ-014 SHALL have ports o_h_cnt, o_l_cnt  output  5 each  number of vectors with H=1 / L=1 (0..16).

Function
REQ-015 SHALL implement the FSM states IDLE, APPLY, SETTLE, CAPTURE and DONE.
REQ-016 SHALL, in IDLE with i_start=1 and i_abort=0, clear idx, both maps and both counts, then go to APPLY.
REQ-017 SHALL spend one cycle in APPLY, SETTLE cycles in SETTLE, and one cycle in CAPTURE, for SETTLE+2 cycles per vector.
REQ-018 SHALL drive {o_O,o_P,o_D,o_M} = idx[3:0] in APPLY, SETTLE and CAPTURE, and drive 4'b0000 in IDLE and DONE.
REQ-019 SHALL, in CAPTURE, write i_H to h_map[idx] and i_L to l_map[idx], and increment each count whose input is 1.
REQ-020 SHALL, in CAPTURE, go to DONE if idx==15; otherwise increment idx and go to APPLY; idx never wraps within a sweep.
REQ-021 SHALL assert o_done only in DONE, for exactly one cycle, at cycle 16*(SETTLE+2)+1 after the start edge, then return to IDLE.
REQ-022 SHALL assert o_busy in APPLY, SETTLE and CAPTURE only.
REQ-023 SHALL ignore i_start outside IDLE.
REQ-024 SHALL, on i_abort=1 in any non-IDLE state, go to IDLE next cycle without o_done; maps and counts keep partial results.
REQ-025 SHALL give i_abort priority when i_start and i_abort are both 1 in IDLE, so the FSM stays in IDLE.
REQ-026 SHALL hold maps and counts stable in IDLE and DONE until the next accepted start.

Reset
REQ-027 SHALL, on i_rst_n=0, immediately set state=IDLE, idx=0, maps=0, counts=0, o_busy=0, o_done=0 and stimulus=0.
REQ-028 SHALL, on reset mid-sweep, discard the sweep; after release it waits for a new i_start.

Structure
REQ-029 SHALL take the state encoding, N_VEC and index width from shared package opdm_pkg.
REQ-030 SHALL be a single module with no sub-module; the opdm instance lives outside, and top opdm_seq_top instantiates both blocks.

Verification
REQ-031 SHALL cover a full sweep: SETTLE=2, a stub with H=O^P and L=D&M, start pulse -> o_done at cycle 65, o_h_map=16'h0FF0, o_l_map=16'h8888, o_h_cnt=8, o_l_cnt=4.
REQ-032 SHALL cover stimulus order: during the sweep, {O,P,D,M} steps 0..15, each value held 4 cycles, with o_busy=1 throughout and 0 in IDLE/DONE.
REQ-033 SHALL cover abort: i_abort at cycle 20 -> IDLE at cycle 21, no o_done, o_h_map bits 0..3 valid and the rest 0.
REQ-034 SHALL cover start while busy: a second i_start at cycle 10 -> ignored, o_done still at cycle 65 only.
REQ-035 SHALL cover simultaneous requests: i_start=i_abort=1 in IDLE -> remains IDLE, o_busy=0.
REQ-036 SHALL cover reset mid-sweep: i_rst_n=0 at cycle 30 -> all outputs 0 at once; after release, a new start gives a correct complete sweep.
